div_share_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one sequential restoring divider among NUM_REQ requesters.
- Accepts one request at a time and latches its operands.
- Runs the divider for exactly WIDTH_A iterations, then returns quotient and remainder tagged with the requester index.
- Sits between the per-channel measurement blocks and the single divider datapath.

---
 rtl/div_share_pkg.sv | 27 ++
 rtl/div_core.sv | 81 ++++++++
 rtl/div_share_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_div_share_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_share_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_share_pkg
// Purpose  : Shared types and constants for the divider-sharing arbiter:
//            sequencer state encoding, tag width helper, and the quotient
//            value reported on divide-by-zero.
// Revision : 1.0  initial release
// ============================================================================
package div_share_pkg;

    // Sequencer states: waiting for a request, iterating, presenting a result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a requester tag; at least one bit so the tag port is never empty.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Quotient returned for a zero divisor; callers slice the width they need.
    localparam logic [63:0] c_dbz_quotient = '1;

endpackage : div_share_pkg
`default_nettype wire

// File: rtl/div_core.sv
`default_nettype none
// ============================================================================
// Module   : div_core
// Purpose  : Sequential restoring divider. One shift/compare/subtract step per
//            clock on a {remainder, quotient} register; WIDTH_A steps per
//            division. done pulses during the cycle of the final step, so q/r
//            hold the finished result from the following cycle onward.
// Revision : 1.0  initial release
// ============================================================================
module div_core #(
    parameter int WIDTH_A = 8,
    parameter int WIDTH_B = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH_A-1:0] a,
    input  logic [WIDTH_B-1:0] b,
    output logic               busy,
    output logic               done,
    output logic [WIDTH_A-1:0] q,
    output logic [WIDTH_B-1:0] r
);

    localparam int CNT_W = $clog2(WIDTH_A + 1);

    logic [WIDTH_A-1:0] r_quo;
    logic [WIDTH_B-1:0] r_rem;
    logic [WIDTH_B-1:0] r_b;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;

    logic [WIDTH_B:0]   w_rem_sh;
    logic               w_ge;
    logic [WIDTH_B-1:0] w_rem_next;
    logic [WIDTH_A-1:0] w_quo_next;
    logic               w_last;

    // One restoring step: the shifted partial remainder is compared at
    // WIDTH_B+1 bits so the bit shifted out of the remainder is not lost.
    // The subtraction itself fits WIDTH_B bits because the remainder stays
    // below the divisor.
    always_comb begin
        w_rem_sh   = {r_rem, r_quo[WIDTH_A-1]};
        w_ge       = (w_rem_sh >= {1'b0, r_b});
        w_rem_next = w_ge ? (w_rem_sh[WIDTH_B-1:0] - r_b) : w_rem_sh[WIDTH_B-1:0];
        w_quo_next = {r_quo[WIDTH_A-2:0], w_ge};
        w_last     = r_busy && (r_cnt == CNT_W'(WIDTH_A - 1));
    end

    // Load operands on start, then iterate until the last step completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quo  <= '0;
            r_rem  <= '0;
            r_b    <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (start) begin
            r_quo  <= a;
            r_rem  <= '0;
            r_b    <= b;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_quo <= w_quo_next;
            r_rem <= w_rem_next;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign busy = r_busy;
    assign done = w_last;
    assign q    = r_quo;
    assign r    = r_rem;

endmodule : div_core
`default_nettype wire

// File: rtl/div_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : div_share_arbiter
// Purpose  : Round-robin arbiter/sequencer sharing one restoring divider among
//            NUM_REQ requesters. Accepts one request at a time, runs the
//            divider, and returns quotient/remainder tagged with the
//            requester index. A zero divisor skips the divider entirely.
// Revision : 1.0  initial release
// ============================================================================
module div_share_arbiter
    import div_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH_A = 8,
    parameter int WIDTH_B = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*WIDTH_A-1:0]   a_in,
    input  logic [NUM_REQ*WIDTH_B-1:0]   b_in,
    output logic [NUM_REQ-1:0]           ack,
    output logic                         rsp_valid,
    output logic [id_w(NUM_REQ)-1:0]     rsp_id,
    output logic [WIDTH_A-1:0]           q,
    output logic [WIDTH_B-1:0]           r,
    output logic                         dbz,
    output logic                         busy
);

    localparam int              ID_W      = id_w(NUM_REQ);
    localparam logic [ID_W-1:0] c_last_id = ID_W'(NUM_REQ - 1);

    state_t             r_state;
    state_t             w_state_next;

    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    r_id;
    logic [ID_W-1:0]    w_grant;
    logic [ID_W-1:0]    w_ptr_next;
    logic [ID_W:0]      w_idx;
    logic               w_found;
    logic               w_accept;
    logic               w_b_zero;
    logic [WIDTH_A-1:0] w_a_sel;
    logic [WIDTH_B-1:0] w_b_sel;

    logic [NUM_REQ-1:0] r_ack;
    logic               r_rsp_valid;
    logic [ID_W-1:0]    r_rsp_id;
    logic [WIDTH_A-1:0] r_q;
    logic [WIDTH_B-1:0] r_r;
    logic               r_dbz;
    logic               r_busy;
    logic               r_zero;
    logic [WIDTH_B-1:0] r_dbz_rem;

    logic               w_core_start;
    logic               w_core_busy;
    logic               w_core_done;
    logic [WIDTH_A-1:0] w_core_q;
    logic [WIDTH_B-1:0] w_core_r;

    // Round-robin pick: first request at or above the pointer, wrapping,
    // then select that requester's operands.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
            if (w_idx >= (ID_W+1)'(NUM_REQ)) begin
                w_idx = w_idx - (ID_W+1)'(NUM_REQ);
            end
            if (!w_found && req[w_idx[ID_W-1:0]]) begin
                w_found = 1'b1;
                w_grant = w_idx[ID_W-1:0];
            end
        end
        w_a_sel = '0;
        w_b_sel = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (w_grant == ID_W'(j)) begin
                w_a_sel = a_in[j*WIDTH_A +: WIDTH_A];
                w_b_sel = b_in[j*WIDTH_B +: WIDTH_B];
            end
        end
        w_ptr_next = (w_grant == c_last_id) ? '0 : (w_grant + ID_W'(1));
        w_b_zero   = (w_b_sel == '0);
        w_accept   = (r_state == IDLE) && w_found;
    end

    // The divider takes its operands straight from the grant mux so that its
    // first step lines up with the ack cycle.
    assign w_core_start = w_accept && !w_b_zero;

    div_core #(
        .WIDTH_A (WIDTH_A),
        .WIDTH_B (WIDTH_B)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_core_start),
        .a     (w_a_sel),
        .b     (w_b_sel),
        .busy  (w_core_busy),
        .done  (w_core_done),
        .q     (w_core_q),
        .r     (w_core_r)
    );

    // Next-state logic; a zero divisor goes straight to DONE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = w_b_zero ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_core_done) begin
                    w_state_next = DONE;
                end else if (!w_core_busy) begin
                    // Defensive: never reached while the divider is healthy.
                    w_state_next = IDLE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Grant bookkeeping and registered response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr    <= '0;
            r_id        <= '0;
            r_zero      <= 1'b0;
            r_dbz_rem   <= '0;
            r_ack       <= '0;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_q         <= '0;
            r_r         <= '0;
            r_dbz       <= 1'b0;
        end else begin
            r_ack       <= '0;
            r_rsp_valid <= (r_state == DONE);
            if (w_accept) begin
                r_ack[w_grant] <= 1'b1;
                r_id           <= w_grant;
                r_rr_ptr       <= w_ptr_next;
                r_zero         <= w_b_zero;
                r_dbz_rem      <= WIDTH_B'(w_a_sel);
                r_busy         <= 1'b1;
            end else if (r_state == IDLE) begin
                r_busy <= 1'b0;
            end
            if (r_state == DONE) begin
                r_rsp_id <= r_id;
                r_dbz    <= r_zero;
                r_q      <= r_zero ? c_dbz_quotient[WIDTH_A-1:0] : w_core_q;
                r_r      <= r_zero ? r_dbz_rem : w_core_r;
            end
        end
    end

    assign ack       = r_ack;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign q         = r_q;
    assign r         = r_r;
    assign dbz       = r_dbz;
    assign busy      = r_busy;

endmodule : div_share_arbiter
`default_nettype wire

// File: tb/tb_div_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_share_arbiter
// Purpose  : Scoreboard bench for div_share_arbiter. A reference model at the
//            clock edge predicts grants and results from the request pattern;
//            a monitor on the opposite edge compares whatever the DUT shows.
// Revision : 1.0  initial release
// ============================================================================
module tb_div_share_arbiter;

    localparam int N  = 4;
    localparam int WA = 8;
    localparam int WB = 8;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req;
    logic [N*WA-1:0]   a_in;
    logic [N*WB-1:0]   b_in;
    logic [N-1:0]      ack;
    logic              rsp_valid;
    logic [IW-1:0]     rsp_id;
    logic [WA-1:0]     q;
    logic [WB-1:0]     r;
    logic              dbz;
    logic              busy;

    always #5 clk = ~clk;

    div_share_arbiter #(.NUM_REQ(N), .WIDTH_A(WA), .WIDTH_B(WB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .ack       (ack),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .q         (q),
        .r         (r),
        .dbz       (dbz),
        .busy      (busy)
    );

    typedef struct {
        int unsigned id;
        int unsigned q;
        int unsigned r;
        int unsigned dbz;
        int unsigned ack_cyc;
        int unsigned rsp_cyc;
    } exp_t;

    typedef struct {
        int unsigned cyc;
        int unsigned id;
    } ack_t;

    exp_t        sb[$];
    ack_t        ack_log[$];
    int unsigned cyc   = 0;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned n_rsp = 0;
    logic [N-1:0] exp_ack = '0;
    int unsigned m_ptr  = 0;
    int unsigned m_free = 0;
    int unsigned last_q, last_r, last_id, last_dbz, last_lat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: at each edge decide whether a request is accepted,
    // which requester wins, and what the answer and its arrival cycle are.
    initial begin
        forever begin
            int unsigned g, a, b;
            bit          found;
            exp_t        e;
            @(posedge clk);
            cyc++;
            exp_ack = '0;
            if (!rst_n) begin
                sb.delete();
                m_ptr  = 0;
                m_free = 0;
            end else if (cyc >= m_free && req != '0) begin
                found = 0;
                g     = 0;
                for (int k = 0; k < N; k++) begin
                    if (!found && req[(m_ptr + k) % N]) begin
                        found = 1;
                        g     = (m_ptr + k) % N;
                    end
                end
                a         = a_in[g*WA +: WA];
                b         = b_in[g*WB +: WB];
                e.id      = g;
                e.dbz     = (b == 0);
                e.q       = (b == 0) ? ((1 << WA) - 1) : (a / b);
                e.r       = (b == 0) ? (a % (1 << WB)) : (a % b);
                e.ack_cyc = cyc;
                e.rsp_cyc = cyc + ((b == 0) ? 1 : WA + 1);
                sb.push_back(e);
                exp_ack[g] = 1'b1;
                m_ptr      = (g + 1) % N;
                m_free     = e.rsp_cyc + 1;
            end
        end
    end

    // Monitor: compare acks, busy and responses mid-cycle.
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (rst_n) begin
                if (ack != '0 || exp_ack != '0) begin
                    check("ack", ack, exp_ack);
                end
                if (ack != '0) begin
                    check("ack_onehot", 64'($onehot(ack)), 1);
                    for (int k = 0; k < N; k++) begin
                        if (ack[k]) ack_log.push_back('{cyc, k});
                    end
                end
                check("busy", busy, (sb.size() > 0) ? 1 : 0);
                if (rsp_valid) begin
                    if (sb.size() == 0) begin
                        check("rsp_unexpected", rsp_valid, 0);
                    end else begin
                        e = sb.pop_front();
                        check("rsp_id", rsp_id, e.id);
                        check("rsp_q", q, e.q);
                        check("rsp_r", r, e.r);
                        check("rsp_dbz", dbz, e.dbz);
                        check("rsp_latency", cyc - e.ack_cyc, e.rsp_cyc - e.ack_cyc);
                        last_q   = q;
                        last_r   = r;
                        last_id  = rsp_id;
                        last_dbz = dbz;
                        last_lat = cyc - e.ack_cyc;
                        n_rsp++;
                    end
                end else if (sb.size() > 0 && cyc > sb[0].rsp_cyc) begin
                    check("rsp_missing", rsp_valid, 1);
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic summary();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    endtask

    initial begin
        #600000;
        n_err++;
        $display("FAIL watchdog: simulation still running, expected completion");
        summary();
        $finish;
    end

    task automatic set_op(input int i, input int unsigned a, input int unsigned b);
        a_in[i*WA +: WA] = WA'(a);
        b_in[i*WB +: WB] = WB'(b);
    endtask

    task automatic wait_ack(input int i);
        bit got = 0;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clk);
            #1;
            if (ack[i]) got = 1;
        end
        if (!got) check("ack_wait", ack[i], 1);
    endtask

    task automatic drain();
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) break;
        end
        @(negedge clk);
        #1;
        check("idle_busy", busy, 0);
    endtask

    task automatic run_one(input string name, input int i, input int unsigned a,
                           input int unsigned b, input int unsigned eq,
                           input int unsigned er, input int unsigned ed);
        set_op(i, a, b);
        req[i] = 1'b1;
        wait_ack(i);
        req[i] = 1'b0;
        drain();
        check({name, "_q"}, last_q, eq);
        check({name, "_r"}, last_r, er);
        check({name, "_id"}, last_id, i);
        check({name, "_dbz"}, last_dbz, ed);
        check({name, "_lat"}, last_lat, ed ? 1 : WA + 1);
    endtask

    function automatic int unsigned rand_a();
        int unsigned p = $urandom_range(9, 0);
        if (p == 0) return 0;
        if (p == 1) return 255;
        return $urandom_range(255, 0);
    endfunction

    function automatic int unsigned rand_b();
        int unsigned p = $urandom_range(9, 0);
        if (p == 0) return 0;
        if (p == 1) return 1;
        if (p == 2) return 255;
        return $urandom_range(255, 0);
    endfunction

    // Random requester behaviour: re-request or drop after ack, occasionally
    // withdraw a pending request, raise new requests with fresh operands.
    task automatic rand_step();
        for (int i = 0; i < N; i++) begin
            if (req[i] && ack[i]) begin
                if ($urandom_range(1, 0) == 1) set_op(i, rand_a(), rand_b());
                else req[i] = 1'b0;
            end else if (req[i]) begin
                if ($urandom_range(99, 0) < 2) req[i] = 1'b0;
            end else if ($urandom_range(99, 0) < 30) begin
                set_op(i, rand_a(), rand_b());
                req[i] = 1'b1;
            end
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ack"}, ack, 0);
        check({name, "_rsp_valid"}, rsp_valid, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_q"}, q, 0);
        check({name, "_r"}, r, 0);
        check({name, "_rsp_id"}, rsp_id, 0);
        check({name, "_dbz"}, dbz, 0);
    endtask

    initial begin
        int unsigned base;
        bit          done_rand;
        rst_n = 1'b0;
        req   = '0;
        a_in  = '0;
        b_in  = '0;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        #1 rst_n = 1'b1;
        @(negedge clk);
        #1;

        run_one("single", 2, 100, 7, 14, 2, 0);
        run_one("dbz", 0, 55, 0, 255, 55, 1);
        run_one("a255_b1", 3, 255, 1, 255, 0, 0);
        run_one("a5_b200", 3, 5, 200, 0, 5, 0);
        run_one("a255_b255", 3, 255, 255, 1, 0, 0);
        run_one("a0_b9", 3, 0, 9, 0, 0, 0);

        // Fairness: all requesters held; pointer is 0 here.
        for (int i = 0; i < N; i++) set_op(i, 200, 3);
        ack_log.delete();
        req = '1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            #1;
            if (ack_log.size() >= 5) break;
        end
        req = '0;
        drain();
        check("fair_acks", ack_log.size(), 5);
        for (int k = 0; k < 5 && k < ack_log.size(); k++) begin
            check($sformatf("fair_id%0d", k), ack_log[k].id, k % 4);
            if (k > 0) check($sformatf("fair_gap%0d", k), ack_log[k].cyc - ack_log[k-1].cyc, WA + 2);
        end
        check("fair_last_q", last_q, 66);
        check("fair_last_r", last_r, 2);

        // Reset in the middle of a division.
        set_op(1, 100, 7);
        req[1] = 1'b1;
        wait_ack(1);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            check("midrst_no_rsp", rsp_valid, 0);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        wait_ack(1);
        req[1] = 1'b0;
        drain();
        check("rerun_q", last_q, 14);
        check("rerun_r", last_r, 2);
        check("rerun_id", last_id, 1);

        // Random traffic until 1000 more responses have been checked.
        base      = n_rsp;
        done_rand = 0;
        for (int c = 0; c < 40000 && !done_rand; c++) begin
            @(negedge clk);
            #1;
            if (n_rsp - base >= 1000) done_rand = 1;
            else rand_step();
        end
        if (!done_rand) check("random_rsp_count", n_rsp - base, 1000);
        req = '0;
        drain();

        summary();
        $finish;
    end

endmodule : tb_div_share_arbiter
`default_nettype wire
